load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory request at a time, range-checks the address,
// issues a single-cycle data-memory access and returns a one-cycle response with
// locally sign/zero-extended load data.
// Optional: define LSU_ALIGN_CHECK_EN to also fault misaligned word/half accesses.
module load_store_unit #(
  parameter logic [31:0] DATA_BASE  = 32'h1001_0000,
  parameter int unsigned DATA_WORDS = 800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_rena,
  output logic        mem_wena,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [5:0]  mem_choice,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam logic [2:0] OpLw  = 3'b000;
  localparam logic [2:0] OpLb  = 3'b001;
  localparam logic [2:0] OpLbu = 3'b010;
  localparam logic [2:0] OpLh  = 3'b011;
  localparam logic [2:0] OpLhu = 3'b100;
  localparam logic [2:0] OpSw  = 3'b101;
  localparam logic [2:0] OpSb  = 3'b110;
  localparam logic [2:0] OpSh  = 3'b111;

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic        fault_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        fault;
  logic        range_fault;
  logic        align_fault;
  logic [31:0] offset;
  logic        is_load;
  logic [31:0] load_ext;

  assign accept = req_valid && (state_q == StIdle);

  // Address fault detection on the incoming request
  always_comb begin
    offset      = req_addr - DATA_BASE;
    range_fault = (req_addr < DATA_BASE) || (offset >= DATA_WORDS);
    align_fault = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    unique case (req_op)
      OpLw, OpSw:        align_fault = (req_addr[1:0] != 2'b00);
      OpLh, OpLhu, OpSh: align_fault = req_addr[0];
      default:           align_fault = 1'b0;
    endcase
`endif
    fault = range_fault || align_fault;
  end

  // Extend raw memory word according to the held load type
  always_comb begin
    is_load  = (op_q <= OpLhu);
    load_ext = mem_rdata;
    unique case (op_q)
      OpLb:    load_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      OpLbu:   load_ext = {24'h0, mem_rdata[7:0]};
      OpLh:    load_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      OpLhu:   load_ext = {16'h0, mem_rdata[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = fault ? StResp : StIssue;
      StIssue: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory strobes and response outputs decoded from state and held op
  always_comb begin
    req_ready  = (state_q == StIdle);
    mem_rena   = 1'b0;
    mem_wena   = 1'b0;
    mem_choice = 6'b000000;
    if (state_q == StIssue) begin
      unique case (op_q)
        OpLw:    mem_rena = 1'b1;
        OpLb:    begin mem_rena = 1'b1; mem_choice = 6'b100000; end
        OpLbu:   begin mem_rena = 1'b1; mem_choice = 6'b010000; end
        OpLh:    begin mem_rena = 1'b1; mem_choice = 6'b001000; end
        OpLhu:   begin mem_rena = 1'b1; mem_choice = 6'b000100; end
        OpSw:    mem_wena = 1'b1;
        OpSb:    mem_choice = 6'b000010;
        OpSh:    mem_choice = 6'b000001;
        default: mem_choice = 6'b000000;
      endcase
    end
    resp_valid = (state_q == StResp);
    resp_err   = (state_q == StResp) && fault_q;
    resp_rdata = (state_q == StResp) ? rdata_q : 32'h0;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
  end

  // State register and request holding registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpLw;
      fault_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= req_op;
        fault_q <= fault;
        rdata_q <= 32'h0;
        // Faulted requests never reach memory, so the memory bus keeps its last value
        if (!fault) begin
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
        end
      end else if (state_q == StIssue) begin
        rdata_q <= is_load ? load_ext : 32'h0;
      end
    end
  end

endmodule
